// File: rtl/instr_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_pipe
//  Description : Pipelined instruction memory for the fetch stage. Returns the
//                addressed word (or NOP_WORD for misses and bubbles) after a
//                fixed LATENCY with a valid strobe and an error flag. A load
//                port writes the program image; flush kills in-flight fetches.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_pipe #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 32,
    parameter int                LATENCY  = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    input  logic              flush_i,
    input  logic              load_en_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic [DATA_W-1:0] instr_o,
    output logic              instr_valid_o,
    output logic              addr_err_o
);

    // Word-index width, and a compare width wide enough to hold both the full
    // index and DEPTH (up to 1024) so the range check never wraps.
    localparam int c_idx_w = ADDR_W - 2;
    localparam int c_cmp_w = (c_idx_w > 11) ? c_idx_w : 11;
    localparam int c_mem_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_cmp_w-1:0] c_depth = c_cmp_w'(DEPTH);

    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [c_cmp_w-1:0]  w_fetch_idx;
    logic [c_cmp_w-1:0]  w_load_idx;
    logic [c_mem_aw-1:0] w_fetch_ptr;
    logic [c_mem_aw-1:0] w_load_ptr;
    logic                w_fetch_hit;
    logic                w_load_hit;
    logic                w_accept;
    logic [DATA_W-1:0]   w_rd_word;

    logic                r_vld  [LATENCY];
    logic [DATA_W-1:0]   r_data [LATENCY];
    logic                r_err  [LATENCY];

    // Address decode: full-width index compare plus alignment check.
    assign w_fetch_idx = c_cmp_w'(instr_addr_i[ADDR_W-1:2]);
    assign w_load_idx  = c_cmp_w'(load_addr_i[ADDR_W-1:2]);
    assign w_fetch_hit = (w_fetch_idx < c_depth) && (instr_addr_i[1:0] == 2'b00);
    assign w_load_hit  = (w_load_idx < c_depth) && (load_addr_i[1:0] == 2'b00);
    assign w_fetch_ptr = w_fetch_idx[c_mem_aw-1:0];
    assign w_load_ptr  = w_load_idx[c_mem_aw-1:0];
    assign w_accept    = enable_i && !flush_i;

    // Read happens from the pre-edge array contents, so a same-cycle load to
    // the same word is not yet visible (read-before-write).
    assign w_rd_word   = r_mem[w_fetch_ptr];

    // Program image storage: cleared to NOP_WORD on reset, written by hit loads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= NOP_WORD;
            end
        end else if (load_en_i && w_load_hit) begin
            r_mem[w_load_ptr] <= load_data_i;
        end
    end

    // First pipeline stage captures the accepted fetch (or a bubble).
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_vld[0]  <= 1'b0;
            r_data[0] <= NOP_WORD;
            r_err[0]  <= 1'b0;
        end else begin
            r_vld[0]  <= w_accept;
            r_data[0] <= (w_accept && w_fetch_hit) ? w_rd_word : NOP_WORD;
            r_err[0]  <= w_accept && !w_fetch_hit;
        end
    end

    // Remaining stages shift forward; flush clears payload too so an invalid
    // output always shows NOP_WORD with no error.
    generate
        for (genvar g = 1; g < LATENCY; g++) begin : g_stage
            always_ff @(posedge clk_i) begin
                if (rst_i || flush_i) begin
                    r_vld[g]  <= 1'b0;
                    r_data[g] <= NOP_WORD;
                    r_err[g]  <= 1'b0;
                end else begin
                    r_vld[g]  <= r_vld[g-1];
                    r_data[g] <= r_data[g-1];
                    r_err[g]  <= r_err[g-1];
                end
            end
        end
    endgenerate

    assign instr_o       = r_data[LATENCY-1];
    assign instr_valid_o = r_vld[LATENCY-1];
    assign addr_err_o    = r_err[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_pipe
//  Description : Scoreboard bench for instr_mem_pipe (ADDR_W=20, DEPTH=32,
//                LATENCY=3). The driver pushes hand-computed responses with
//                their due cycle; a negedge monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_pipe;

    localparam int          AW  = 20;
    localparam int          LAT = 3;
    localparam logic [31:0] NOP = 32'h0;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [AW-1:0] instr_addr;
    logic          flush;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          addr_err;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_on = 1'b0;

    instr_mem_pipe #(
        .ADDR_W   (AW),
        .DATA_W   (32),
        .DEPTH    (32),
        .LATENCY  (LAT),
        .NOP_WORD (NOP)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .instr_addr_i  (instr_addr),
        .flush_i       (flush),
        .load_en_i     (load_en),
        .load_addr_i   (load_addr),
        .load_data_i   (load_data),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .addr_err_o    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pop one expectation per valid response; idle cycles must be clean.
    always @(negedge clk) begin
        if (mon_on) begin
            if (instr_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_valid at cycle %0d: instr=0x%08h err=%0b, expected no response",
                             cyc, instr, addr_err);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_data", instr, mon_e.data);
                    check("resp_err", {31'b0, addr_err}, {31'b0, mon_e.err});
                    check("resp_cycle", cyc, mon_e.due);
                end
            end else begin
                check("idle_valid", {31'b0, instr_valid}, 32'h0);
                check("idle_data", instr, NOP);
                check("idle_err", {31'b0, addr_err}, 32'h0);
            end
            if (sb.size() > 0 && sb[0].due < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL missing_response at cycle %0d: nothing seen, expected 0x%08h due cycle %0d",
                         cyc, sb[0].data, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable  = 1'b0;
        flush   = 1'b0;
        load_en = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic [31:0] d, input logic e, input bit expect_out);
        enable     = 1'b1;
        instr_addr = a;
        if (expect_out) sb.push_back('{due: cyc + LAT, data: d, err: e});
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst        = 1'b1;
        instr_addr = '0;
        load_addr  = '0;
        load_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_on = 1'b1;
        repeat (2) tick();

        // Program image, then back-to-back fetches
        load(20'h0, 32'h00000013);     tick();
        load(20'h4, 32'h00100093);     tick();
        load(20'h8, 32'h00200113);     tick();
        load(20'hC, 32'h11111111);     tick();
        load_en = 1'b0;
        fetch(20'h0, 32'h00000013, 1'b0, 1'b1); tick();
        fetch(20'h4, 32'h00100093, 1'b0, 1'b1); tick();
        fetch(20'h8, 32'h00200113, 1'b0, 1'b1); tick();
        idle(); repeat (5) tick();

        // Illegal loads must be dropped without aliasing
        load(20'h80,    32'hBAD0BAD0); tick();
        load(20'h06,    32'hBAD1BAD1); tick();
        load(20'h40000, 32'hBAD2BAD2); tick();
        idle();

        // Misses, boundaries, and proof that memory was untouched
        fetch(20'h80,    NOP, 1'b1, 1'b1); tick();
        fetch(20'h06,    NOP, 1'b1, 1'b1); tick();
        fetch(20'h40000, NOP, 1'b1, 1'b1); tick();
        fetch(20'h7C,    NOP, 1'b0, 1'b1); tick();
        fetch(20'h7E,    NOP, 1'b1, 1'b1); tick();
        fetch(20'h0, 32'h00000013, 1'b0, 1'b1); tick();
        fetch(20'h4, 32'h00100093, 1'b0, 1'b1); tick();
        idle(); repeat (5) tick();

        // Same-cycle load/fetch returns the old word; next cycle sees the new one
        load(20'hC, 32'hDEADBEEF);
        fetch(20'hC, 32'h11111111, 1'b0, 1'b1); tick();
        load_en = 1'b0;
        fetch(20'hC, 32'hDEADBEEF, 1'b0, 1'b1); tick();
        idle(); repeat (5) tick();

        // Flush kills in-flight fetches; a load in the flush cycle completes
        fetch(20'h0, NOP, 1'b0, 1'b0); tick();
        fetch(20'h4, NOP, 1'b0, 1'b0); tick();
        fetch(20'h8, NOP, 1'b0, 1'b0);
        flush = 1'b1;
        load(20'h10, 32'hCAFEF00D);    tick();
        flush   = 1'b0;
        load_en = 1'b0;
        fetch(20'h10, 32'hCAFEF00D, 1'b0, 1'b1); tick();
        idle(); repeat (5) tick();

        // Enable toggling 1,0,1 creates a bubble
        fetch(20'h0, 32'h00000013, 1'b0, 1'b1); tick();
        enable     = 1'b0;
        instr_addr = 20'h8;                     tick();
        fetch(20'h4, 32'h00100093, 1'b0, 1'b1); tick();
        idle(); repeat (5) tick();

        // Reset with fetches in flight; load and fetch during reset are ignored
        load(20'h0, 32'h12345678);     tick();
        load_en = 1'b0;
        fetch(20'h0, NOP, 1'b0, 1'b0); tick();
        fetch(20'h4, NOP, 1'b0, 1'b0); tick();
        rst = 1'b1;
        fetch(20'h0, NOP, 1'b0, 1'b0);
        load(20'h8, 32'h55555555);     tick();
        idle(); repeat (6) tick();
        fetch(20'h0, NOP, 1'b0, 1'b1); tick();
        fetch(20'h8, NOP, 1'b0, 1'b1); tick();
        idle(); repeat (6) tick();

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_mem_pipe.md
# instr_mem_pipe

Parametrised, pipelined instruction memory for the simple core's fetch stage. Holds DEPTH words of DATA_W bits. A fetch request returns the addressed word, or NOP_WORD for out-of-range/misaligned/disabled fetches, after a fixed LATENCY cycles with a valid strobe and an error flag. A load port writes the program image after reset; a flush input kills in-flight fetches on redirect.

## Interface

- ADDR_W, 16: byte-address width of fetch and load addresses.
- DATA_W, 32: instruction word width.
- DEPTH, 32: number of words; legal range 2..1024.
- LATENCY, 1: request-to-response cycles; legal range 1..4.
- NOP_WORD, 32'h0: word returned for any non-hit fetch; also the memory reset value.

- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- enable_i  in  1  fetch request qualifier, sampled every cycle.
- instr_addr_i  in  ADDR_W  fetch byte address.
- flush_i  in  1  kill all in-flight fetches.
- load_en_i  in  1  write strobe for the program image.
- load_addr_i  in  ADDR_W  byte address of the write.
- load_data_i  in  DATA_W  word to write.
- instr_o  out  DATA_W  fetched word.
- instr_valid_o  out  1  instr_o/addr_err_o are valid this cycle.
- addr_err_o  out  1  the returned fetch was out-of-range or misaligned.

## Operation

- Word index = addr >> 2. An address is a hit when index < DEPTH and addr[1:0] == 0.
- Fetch is accepted in every cycle where enable_i=1 and flush_i=0. There is no backpressure.
- Accepted hit: read mem[index] in the accept cycle.
- Accepted miss:
  - Carry NOP_WORD.
  - Set the error bit: 1 if index >= DEPTH or addr[1:0] != 0.
  - Index is compared at full ADDR_W-2 width, so there is no wrap-around.
- A cycle with enable_i=0 injects a bubble: valid=0, data NOP_WORD, err=0.
- The pipeline has LATENCY stages. Each stage holds {valid, data, err}. Stage LATENCY-1 drives the outputs directly.
- While instr_valid_o=0: instr_o=NOP_WORD and addr_err_o=0.
- Load:
  - When load_en_i=1, load_addr_i is a hit, and rst_i=0, write mem[index] at the clock edge.
  - Misaligned or out-of-range loads are silently dropped.
  - Load and fetch are independent and may occur in the same cycle.
- Same-cycle load and fetch to the same index: the fetch returns the OLD word (read-before-write).
- flush_i=1: clears the valid bit of every stage and ignores a fetch presented in that cycle. A load in the same cycle still completes.
- rst_i=1:
  - All stage valids, data and err are set to 0 / NOP_WORD / 0.
  - All DEPTH memory words are set to NOP_WORD.
  - Load and fetch in the reset cycle are ignored.
  - Reset mid-pipeline discards in-flight fetches; nothing emerges after reset deasserts.

## Timing

- Fetch accepted in cycle N: instr_valid_o=1 with its data and err in cycle N+LATENCY. There is no combinational input-to-output path.
- Throughput: one fetch per cycle. Responses come out in request order, one-to-one with accepted requests.
- Load written at the edge ending cycle N is visible to a fetch accepted in cycle N+1.
- Flush asserted in cycle N:
  - No valid output in cycles N+1..N+LATENCY from fetches accepted before N+1.
  - A fetch accepted in N+1 appears in N+1+LATENCY.
- Outputs after reset: instr_o=NOP_WORD, instr_valid_o=0, addr_err_o=0, starting the cycle after the reset edge.

## Test plan

- Load words 0x00000013, 0x00100093, 0x00200113 at byte addresses 0, 4, 8. Then fetch 0, 4, 8 back-to-back with LATENCY=2 -> the three words appear with valid=1, err=0 in cycles +2, +3, +4.
- Fetch byte 0x80 (index 32, DEPTH=32) and byte 0x06 -> both return NOP_WORD, valid=1, err=1. Fetch 0x40000 with ADDR_W=20 -> err=1, no aliasing to index 0.
- Load 0xDEADBEEF to addr 12 while fetching addr 12 in the same cycle -> the response is the old word. A refetch the next cycle returns 0xDEADBEEF.
- LATENCY=3: fetches at cycles 0, 1, 2, then flush_i in cycle 2 -> no valid outputs in cycles 3..5. A fetch in cycle 3 returns in cycle 6.
- Assert rst_i with two fetches in flight after loading 0x12345678 at addr 0 -> no valid output after reset. A fetch of addr 0 returns NOP_WORD, err=0.
- enable_i toggling 1,0,1 -> valid pattern 1,0,1 delayed by LATENCY. instr_o=NOP_WORD in the bubble cycle.
